grad_descent_top: RTL and testbench

- Hardware gradient-descent minimiser for a fixed four-variable quadratic cost f(a,b,c,d) = (a-TA)^2 + (b-TB)^2 + (c-TC)^2 + (d-TD)^2.
- Takes 8-bit signed integer starting points and iterates in Q24.8 fixed point until every gradient lies inside a convergence window, or until an iteration cap is reached.
- Reports the minimum cost and the argmin.
- Sits as a standalone accelerator under a simple start/done handshake.

---
 rtl/gd_pkg.sv | 49 ++++
 rtl/gd_axis_unit.sv | 49 ++++
 rtl/grad_descent_top.sv | 172 +++++++++++++++++
 tb/tb_grad_descent_top.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gd_pkg.sv
// rtl/gd_pkg.sv - shared Q24.8 constants, FSM state encoding and fixed-point helpers
//
// Purpose: common definitions for the gradient-descent minimiser.
//   FRAC_BITS / WORD  : Q24.8 format (8 fractional bits in a 32-bit word)
//   gd_state_t        : controller states
//   int8_to_q         : signed 8-bit integer -> Q24.8
//   sat_cost          : non-negative 64-bit cost -> 32-bit, clamped at 0x7FFF_FFFF
//   round_sat_int8    : Q24.8 -> nearest integer (half rounds up), clamped to [-128,127]
package gd_pkg;

  localparam int FRAC_BITS = 8;
  localparam int WORD      = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GRAD,
    CHECK,
    UPDATE,
    EVAL,
    DONE
  } gd_state_t;

  function automatic logic signed [WORD-1:0] int8_to_q(input logic signed [7:0] v);
    return {{(WORD-8-FRAC_BITS){v[7]}}, v, {FRAC_BITS{1'b0}}};
  endfunction

  // The summed squared errors are never negative, so only the top end needs clamping.
  function automatic logic signed [WORD-1:0] sat_cost(input logic [63:0] s);
    if (s > 64'h0000_0000_7FFF_FFFF) begin
      return 32'h7FFF_FFFF;
    end
    return s[WORD-1:0];
  endfunction

  // One guard bit keeps x + 0.5 from wrapping when x sits near the positive limit.
  function automatic logic signed [7:0] round_sat_int8(input logic signed [WORD-1:0] x);
    logic signed [WORD:0] r;
    r = ($signed({x[WORD-1], x}) + 33'sd128) >>> FRAC_BITS;
    if (r > 33'sd127) begin
      return 8'h7F;
    end
    if (r < -33'sd128) begin
      return 8'h80;
    end
    return r[7:0];
  endfunction

endpackage

// File: rtl/gd_axis_unit.sv
// rtl/gd_axis_unit.sv - per-coordinate gradient, window test, step and squared error
//
// Purpose: purely combinational datapath for one coordinate of the quadratic cost.
// Ports:
//   x         in   32  current coordinate, Q24.8
//   grad_reg  in   32  gradient registered by the controller, Q24.8
//   target    in    8  integer minimiser coordinate
//   lr        in   32  step size, Q24.8
//   lower     in   32  inclusive lower gradient bound, Q24.8
//   upper     in   32  inclusive upper gradient bound, Q24.8
//   grad      out  32  2*(x - target) from the current x
//   in_window out   1  grad_reg lies inside [lower, upper]
//   x_next    out  32  x - (lr*grad_reg >>> 8)
//   sq_term   out  64  (x - target)^2 >>> 8, Q24.8
module gd_axis_unit
  import gd_pkg::*;
(
  input  logic signed [WORD-1:0] x,
  input  logic signed [WORD-1:0] grad_reg,
  input  logic signed [7:0]      target,
  input  logic signed [WORD-1:0] lr,
  input  logic signed [WORD-1:0] lower,
  input  logic signed [WORD-1:0] upper,
  output logic signed [WORD-1:0] grad,
  output logic                   in_window,
  output logic signed [WORD-1:0] x_next,
  output logic        [63:0]     sq_term
);

  logic signed [WORD-1:0]   target_q;
  logic signed [2*WORD-1:0] prod;
  logic signed [WORD:0]     diff;
  logic signed [2*WORD+1:0] sq;

  assign target_q  = int8_to_q(target);
  assign grad      = (x - target_q) <<< 1;
  assign in_window = (grad_reg >= lower) && (grad_reg <= upper);

  // Both operands are sign-extended to 64 bits, so the low 64 bits of the
  // product are the exact signed product.
  assign prod   = {{WORD{lr[WORD-1]}}, lr} * {{WORD{grad_reg[WORD-1]}}, grad_reg};
  assign x_next = x - WORD'(prod >>> FRAC_BITS);

  // The error gets one extra bit so an extreme x cannot wrap before squaring.
  assign diff    = {x[WORD-1], x} - {target_q[WORD-1], target_q};
  assign sq      = diff * diff;
  assign sq_term = 64'(sq >>> FRAC_BITS);

endmodule

// File: rtl/grad_descent_top.sv
// rtl/grad_descent_top.sv - four-variable quadratic gradient-descent minimiser
//
// Purpose: iterates x_v <= x_v - lr_v*g_v in Q24.8 from 8-bit integer start
// points until every gradient is inside the window or the iteration cap is hit,
// then reports the cost and the rounded argmin.
// Ports:
//   clk                   in   1  rising-edge clock
//   rst_n                 in   1  asynchronous active-low reset
//   start_op              in   1  level start request
//   a/b/c/d_initial       in   8  signed integer start points (sampled in LOAD)
//   z_min                 out 32  signed Q24.8 cost at the final point
//   final_a/b/c/d_at_min  out  8  signed integer final coordinates
//   done_op               out  1  result valid, held until start_op drops
module grad_descent_top
  import gd_pkg::*;
#(
  parameter int unsigned     NUM_ITERATIONS   = 50,
  parameter logic [WORD-1:0] LEARNING_RATE_A  = 32'h0000_0011,
  parameter logic [WORD-1:0] LEARNING_RATE_B  = 32'h0000_0011,
  parameter logic [WORD-1:0] LEARNING_RATE_C  = 32'h0000_0011,
  parameter logic [WORD-1:0] LEARNING_RATE_D  = 32'h0000_0010,
  parameter logic [WORD-1:0] LOWER_CONV_BOUND = 32'hFFFF_FFC0,
  parameter logic [WORD-1:0] UPPER_CONV_BOUND = 32'h0000_0040,
  parameter int              TARGET_A         = 3,
  parameter int              TARGET_B         = -2,
  parameter int              TARGET_C         = 1,
  parameter int              TARGET_D         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_op,
  input  logic signed [7:0]      a_initial,
  input  logic signed [7:0]      b_initial,
  input  logic signed [7:0]      c_initial,
  input  logic signed [7:0]      d_initial,
  output logic signed [WORD-1:0] z_min,
  output logic signed [7:0]      final_a_at_min,
  output logic signed [7:0]      final_b_at_min,
  output logic signed [7:0]      final_c_at_min,
  output logic signed [7:0]      final_d_at_min,
  output logic                   done_op
);

  localparam int ITER_W = $clog2(NUM_ITERATIONS + 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NUM_ITERATIONS);

  gd_state_t state;

  logic [ITER_W-1:0] iter_count;
  logic              converged;

  logic signed [WORD-1:0] x_a, x_b, x_c, x_d;
  logic signed [WORD-1:0] g_a, g_b, g_c, g_d;

  logic signed [WORD-1:0] grad_a, grad_b, grad_c, grad_d;
  logic signed [WORD-1:0] x_next_a, x_next_b, x_next_c, x_next_d;
  logic        [63:0]     sq_a, sq_b, sq_c, sq_d;
  logic        [3:0]      win;
  logic        [63:0]     cost_sum;

  gd_axis_unit u_axis_a (
    .x(x_a), .grad_reg(g_a), .target(8'(TARGET_A)), .lr(LEARNING_RATE_A),
    .lower(LOWER_CONV_BOUND), .upper(UPPER_CONV_BOUND),
    .grad(grad_a), .in_window(win[0]), .x_next(x_next_a), .sq_term(sq_a)
  );

  gd_axis_unit u_axis_b (
    .x(x_b), .grad_reg(g_b), .target(8'(TARGET_B)), .lr(LEARNING_RATE_B),
    .lower(LOWER_CONV_BOUND), .upper(UPPER_CONV_BOUND),
    .grad(grad_b), .in_window(win[1]), .x_next(x_next_b), .sq_term(sq_b)
  );

  gd_axis_unit u_axis_c (
    .x(x_c), .grad_reg(g_c), .target(8'(TARGET_C)), .lr(LEARNING_RATE_C),
    .lower(LOWER_CONV_BOUND), .upper(UPPER_CONV_BOUND),
    .grad(grad_c), .in_window(win[2]), .x_next(x_next_c), .sq_term(sq_c)
  );

  gd_axis_unit u_axis_d (
    .x(x_d), .grad_reg(g_d), .target(8'(TARGET_D)), .lr(LEARNING_RATE_D),
    .lower(LOWER_CONV_BOUND), .upper(UPPER_CONV_BOUND),
    .grad(grad_d), .in_window(win[3]), .x_next(x_next_d), .sq_term(sq_d)
  );

  // Each term is at most 2^56, so four of them cannot overflow 64 bits.
  assign cost_sum = sq_a + sq_b + sq_c + sq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      iter_count     <= '0;
      converged      <= 1'b0;
      x_a            <= '0;
      x_b            <= '0;
      x_c            <= '0;
      x_d            <= '0;
      g_a            <= '0;
      g_b            <= '0;
      g_c            <= '0;
      g_d            <= '0;
      z_min          <= '0;
      final_a_at_min <= '0;
      final_b_at_min <= '0;
      final_c_at_min <= '0;
      final_d_at_min <= '0;
      done_op        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_op) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          x_a        <= int8_to_q(a_initial);
          x_b        <= int8_to_q(b_initial);
          x_c        <= int8_to_q(c_initial);
          x_d        <= int8_to_q(d_initial);
          iter_count <= '0;
          converged  <= 1'b0;
          state      <= GRAD;
        end
        GRAD: begin
          g_a   <= grad_a;
          g_b   <= grad_b;
          g_c   <= grad_c;
          g_d   <= grad_d;
          state <= CHECK;
        end
        CHECK: begin
          // Convergence wins over the cap: a point that lands in the window on
          // the last allowed step still reports converged.
          if (&win) begin
            converged <= 1'b1;
            state     <= EVAL;
          end else if (iter_count == ITER_MAX) begin
            state <= EVAL;
          end else begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          x_a        <= x_next_a;
          x_b        <= x_next_b;
          x_c        <= x_next_c;
          x_d        <= x_next_d;
          iter_count <= iter_count + 1'b1;
          state      <= GRAD;
        end
        EVAL: begin
          z_min          <= sat_cost(cost_sum);
          final_a_at_min <= round_sat_int8(x_a);
          final_b_at_min <= round_sat_int8(x_b);
          final_c_at_min <= round_sat_int8(x_c);
          final_d_at_min <= round_sat_int8(x_d);
          done_op        <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (!start_op) begin
            done_op <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grad_descent_top.sv
// tb/tb_grad_descent_top.sv - scoreboard bench for grad_descent_top
module tb_grad_descent_top;

  localparam int NUM_IT = 50;

  logic              clk;
  logic              rst_n;
  logic              start_op;
  logic              start_lr0;
  logic signed [7:0] a_in, b_in, c_in, d_in;
  logic signed [31:0] z_min, z_min0;
  logic signed [7:0] fa, fb, fc, fd;
  logic signed [7:0] fa0, fb0, fc0, fd0;
  logic              done_op, done0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int z;
    int fa;
    int fb;
    int fc;
    int fd;
    int iters;
    bit conv;
    int start_cyc;
  } exp_t;

  exp_t sb_q[$];

  grad_descent_top dut (
    .clk(clk), .rst_n(rst_n), .start_op(start_op),
    .a_initial(a_in), .b_initial(b_in), .c_initial(c_in), .d_initial(d_in),
    .z_min(z_min),
    .final_a_at_min(fa), .final_b_at_min(fb), .final_c_at_min(fc), .final_d_at_min(fd),
    .done_op(done_op)
  );

  grad_descent_top #(
    .LEARNING_RATE_A(32'h0), .LEARNING_RATE_B(32'h0),
    .LEARNING_RATE_C(32'h0), .LEARNING_RATE_D(32'h0)
  ) dut_lr0 (
    .clk(clk), .rst_n(rst_n), .start_op(start_lr0),
    .a_initial(a_in), .b_initial(b_in), .c_initial(c_in), .d_initial(d_in),
    .z_min(z_min0),
    .final_a_at_min(fa0), .final_b_at_min(fb0), .final_c_at_min(fc0), .final_d_at_min(fd0),
    .done_op(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: straight iteration of the update rule on integers.
  function automatic exp_t model(input int ia, input int ib, input int ic, input int id,
                                 input bit zero_lr);
    exp_t   e;
    int     tgt[4];
    int     lr[4];
    int     x[4];
    int     g[4];
    int     fin[4];
    bit     all_in;
    longint s;
    longint d;
    longint r;
    tgt = '{3, -2, 1, 4};
    if (zero_lr) lr = '{0, 0, 0, 0};
    else         lr = '{17, 17, 17, 16};
    x = '{ia * 256, ib * 256, ic * 256, id * 256};
    e.iters = 0;
    e.conv  = 1'b0;
    for (int it = 0; it <= NUM_IT; it++) begin
      all_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        g[k] = 2 * (x[k] - tgt[k] * 256);
        if (g[k] < -64 || g[k] > 64) all_in = 1'b0;
      end
      if (all_in) begin
        e.conv = 1'b1;
        break;
      end
      if (it == NUM_IT) break;
      for (int k = 0; k < 4; k++) begin
        x[k] = int'(longint'(x[k]) - ((longint'(lr[k]) * longint'(g[k])) >>> 8));
      end
      e.iters++;
    end
    s = 0;
    for (int k = 0; k < 4; k++) begin
      d = longint'(x[k]) - longint'(tgt[k]) * 256;
      s += (d * d) >>> 8;
      r = (longint'(x[k]) + 128) >>> 8;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      fin[k] = int'(r);
    end
    e.z  = (s > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : int'(s);
    e.fa = fin[0];
    e.fb = fin[1];
    e.fc = fin[2];
    e.fd = fin[3];
    e.start_cyc = 0;
    return e;
  endfunction

  // Monitor: compares each completed run against the oldest expectation.
  bit done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_op && !done_prev) begin
      check("sb_queue_depth", longint'(sb_q.size()), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_z_min", z_min, e.z);
        check("sb_final_a", fa, e.fa);
        check("sb_final_b", fb, e.fb);
        check("sb_final_c", fc, e.fc);
        check("sb_final_d", fd, e.fd);
        check("sb_iter_count", dut.iter_count, e.iters);
        check("sb_converged", dut.converged, e.conv);
        check("sb_latency", cyc - e.start_cyc, 4 + 3 * e.iters);
      end
    end
    done_prev = done_op;
  end

  task automatic run_main(input int a, input int b, input int c, input int d,
                          input bit chk_first, output exp_t e);
    bit seen;
    bit first_checked;
    @(negedge clk);
    a_in = 8'(a);
    b_in = 8'(b);
    c_in = 8'(c);
    d_in = 8'(d);
    e = model(a, b, c, d, 1'b0);
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
    start_op = 1'b1;
    seen = 1'b0;
    first_checked = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (chk_first && !first_checked && dut.iter_count == 1) begin
        check("first_update_x_a", dut.x_a, 32'h66);
        check("first_update_x_d", dut.x_d, 32'h80);
        first_checked = 1'b1;
      end
      if (done_op) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (chk_first) check("first_update_seen", first_checked, 1);
    if (!seen) sb_q.delete();
    start_op = 1'b0;
    @(negedge clk);
    check("done_clear", done_op, 0);
    check("idle_hold_z", z_min, e.z);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("pulse_rst_final_a", fa, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    exp_t e0;
    int   s0;
    int   ra, rb, rc, rd;
    bit   seen;

    rst_n = 1'b0;
    start_op = 1'b1;
    start_lr0 = 1'b0;
    a_in = '0;
    b_in = '0;
    c_in = '0;
    d_in = '0;
    repeat (3) @(negedge clk);
    check("rst_done_op", done_op, 0);
    check("rst_z_min", z_min, 0);
    check("rst_final_a", fa, 0);
    check("rst_final_b", fb, 0);
    check("rst_final_c", fc, 0);
    check("rst_final_d", fd, 0);
    check("rst_iter_count", dut.iter_count, 0);
    check("rst_converged", dut.converged, 0);
    start_op = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start exactly at the minimiser.
    run_main(3, -2, 1, 4, 1'b0, e);
    check("at_target_iters", dut.iter_count, 0);
    check("at_target_conv", dut.converged, 1);
    check("at_target_z", z_min, 0);

    // Sweep as in system use.
    for (int v = 0; v < 49; v++) begin
      run_main(v, v, v, v, v == 0, e);
      check("sweep_conv", dut.converged, 1);
      check("sweep_iter_below_cap", dut.iter_count < NUM_IT, 1);
      check("sweep_final_a", fa, 3);
      check("sweep_final_b", fb, -2);
      check("sweep_final_c", fc, 1);
      check("sweep_final_d", fd, 4);
      check("sweep_z_small", (z_min < 32'sh40) && (z_min > -32'sh40), 1);
      pulse_reset();
    end

    // Zero learning rate: never moves, hits the cap.
    @(negedge clk);
    a_in = '0;
    b_in = '0;
    c_in = '0;
    d_in = '0;
    e0 = model(0, 0, 0, 0, 1'b1);
    s0 = cyc + 1;
    start_lr0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    check("lr0_done_seen", seen, 1);
    check("lr0_latency", cyc - s0, 4 + 3 * NUM_IT);
    check("lr0_z_min", z_min0, 32'h1E00);
    check("lr0_z_model", z_min0, e0.z);
    check("lr0_final_a", fa0, 0);
    check("lr0_final_b", fb0, 0);
    check("lr0_final_c", fc0, 0);
    check("lr0_final_d", fd0, 0);
    check("lr0_iter_count", dut_lr0.iter_count, NUM_IT);
    check("lr0_converged", dut_lr0.converged, 0);
    start_lr0 = 1'b0;
    @(negedge clk);
    check("lr0_done_clear", done0, 0);

    // Extremes.
    run_main(-128, 127, -128, 127, 1'b0, e);
    check("ext_a_toward", (int'(fa) >= -128) && (int'(fa) <= 3), 1);
    check("ext_b_toward", (int'(fb) >= -2) && (int'(fb) <= 127), 1);
    check("ext_c_toward", (int'(fc) >= -128) && (int'(fc) <= 1), 1);
    check("ext_d_toward", (int'(fd) >= 4) && (int'(fd) <= 127), 1);
    check("ext_conv_or_target",
          (!dut.converged) || (fa == 3 && fb == -2 && fc == 1 && fd == 4), 1);

    // Random start points.
    for (int n = 0; n < 10; n++) begin
      ra = int'($urandom_range(0, 255)) - 128;
      rb = int'($urandom_range(0, 255)) - 128;
      rc = int'($urandom_range(0, 255)) - 128;
      rd = int'($urandom_range(0, 255)) - 128;
      run_main(ra, rb, rc, rd, 1'b0, e);
    end

    // Reset in the middle of a run, then a clean restart.
    @(negedge clk);
    a_in = -8'sd100;
    b_in = 8'sd90;
    c_in = 8'sd50;
    d_in = -8'sd60;
    start_op = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dut.iter_count == 5) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_reach_iter5", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_done_op", done_op, 0);
    check("mid_rst_z_min", z_min, 0);
    check("mid_rst_final_a", fa, 0);
    check("mid_rst_final_b", fb, 0);
    check("mid_rst_final_c", fc, 0);
    check("mid_rst_final_d", fd, 0);
    check("mid_rst_iter_count", dut.iter_count, 0);
    start_op = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_main(-100, 90, 50, -60, 1'b0, e);

    repeat (3) @(negedge clk);
    check("sb_drained", longint'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
